fft_iter_sequencer: RTL and testbench

Parametrised butterfly/stage sequencer for the radix-2 DIT FFT datapath, generalising the fixed 16-group iteration counter. It tracks the butterfly index within a stage and the stage index for any 2^LOG2_POINTS transform. It also generates the butterfly operand addresses and twiddle index. It sits between the FFT control FSM, which issues start and iteration strobes, and the sample RAM and twiddle ROM address ports.

---
 rtl/fft_iter_sequencer.sv | 146 ++++++++++++++
 tb/tb_fft_iter_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_iter_sequencer.sv
// Butterfly/stage sequencer for a radix-2 DIT FFT of 2^LOG2_POINTS points.
// Counts butterflies k within a stage and stages s, then derives the sample
// RAM operand addresses and the twiddle ROM index combinationally from the
// registered counts.
//
// Build option: define FFT_ITER_TWIDDLE_EN to generate twiddle_addr. When it
// is undefined, twiddle_addr is tied to zero for use with an external twiddle
// generator.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start, counts held at zero
// RUN   | transform in progress, iteration_strobe advances k (and s)
// DONE  | single cycle after the final butterfly, returns to IDLE
module fft_iter_sequencer #(
  parameter int LOG2_POINTS = 5,
  parameter int STAGE_W     = $clog2(LOG2_POINTS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   clear,
  input  logic                   iteration_strobe,
  output logic                   busy,
  output logic                   stage_strobe,
  output logic                   done,
  output logic [LOG2_POINTS-2:0] butterfly_count,
  output logic [STAGE_W-1:0]     stage_count,
  output logic [LOG2_POINTS-1:0] addr_a,
  output logic [LOG2_POINTS-1:0] addr_b,
  output logic [LOG2_POINTS-2:0] twiddle_addr
);

  localparam int K_W = LOG2_POINTS - 1;
  localparam logic [K_W-1:0]     K_LAST = '1;
  localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(LOG2_POINTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [K_W-1:0]     k_nx;
  logic [STAGE_W-1:0] s_nx;
  logic               stage_strobe_nx;
  logic               done_nx;

  // State, counters and the registered pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      butterfly_count <= '0;
      stage_count     <= '0;
      stage_strobe    <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_nx;
      butterfly_count <= k_nx;
      stage_count     <= s_nx;
      stage_strobe    <= stage_strobe_nx;
      done            <= done_nx;
    end
  end

  // Next-state and counter update; clear wins over start and strobes.
  always_comb begin
    state_nx        = state;
    k_nx            = butterfly_count;
    s_nx            = stage_count;
    stage_strobe_nx = 1'b0;
    done_nx         = 1'b0;
    if (clear) begin
      state_nx = IDLE;
      k_nx     = '0;
      s_nx     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nx = RUN;
            k_nx     = '0;
            s_nx     = '0;
          end
        end
        RUN: begin
          if (iteration_strobe) begin
            if (butterfly_count == K_LAST) begin
              k_nx            = '0;
              stage_strobe_nx = 1'b1;
              if (stage_count == S_LAST) begin
                s_nx     = '0;
                state_nx = DONE;
                done_nx  = 1'b1;
              end else begin
                s_nx = stage_count + 1'b1;
              end
            end else begin
              k_nx = butterfly_count + 1'b1;
            end
          end
        end
        DONE: begin
          state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
          k_nx     = '0;
          s_nx     = '0;
        end
      endcase
    end
  end

  assign busy = (state == RUN);

  // Operand addressing. All arithmetic is done at LOG2_POINTS bits; the
  // group shift is split into "<< s" then "<< 1" so the shift amount never
  // has to hold s+1, which can overflow STAGE_W.
  logic [LOG2_POINTS-1:0] k_ext;
  logic [LOG2_POINTS-1:0] half_span;
  logic [LOG2_POINTS-1:0] group_idx;
  logic [LOG2_POINTS-1:0] pos;

  assign k_ext     = {1'b0, butterfly_count};
  assign half_span = LOG2_POINTS'(1) << stage_count;
  assign group_idx = k_ext >> stage_count;
  assign pos       = k_ext & (half_span - 1'b1);
  assign addr_a    = ((group_idx << stage_count) << 1) | pos;
  assign addr_b    = addr_a + half_span;

`ifdef FFT_ITER_TWIDDLE_EN
  // pos < 2^s <= N/2, so it always fits the twiddle width; shifting the
  // narrowed value gives the same result as shifting at full width and
  // truncating.
  logic [STAGE_W-1:0] tw_shift;

  assign tw_shift     = S_LAST - stage_count;
  assign twiddle_addr = pos[K_W-1:0] << tw_shift;
`else
  assign twiddle_addr = '0;
`endif

endmodule

// File: tb/tb_fft_iter_sequencer.sv
// Bench for fft_iter_sequencer: an N=32 and an N=8 instance share the same
// control inputs. A behavioural model driven by accepted-strobe counts feeds
// a scoreboard queue each cycle; addressing is checked against a constant
// vector table.
module tb_fft_iter_sequencer;

  logic clk = 1'b0;
  logic reset, start, clear, iteration_strobe;

  logic       busy5, ss5, dn5;
  logic [3:0] bc5;
  logic [2:0] sc5;
  logic [4:0] aa5, ab5;
  logic [3:0] tw5;

  logic       busy3, ss3, dn3;
  logic [1:0] bc3;
  logic [1:0] sc3;
  logic [2:0] aa3, ab3;
  logic [1:0] tw3;

  always #5 clk = ~clk;

  fft_iter_sequencer #(.LOG2_POINTS(5)) dut5 (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .iteration_strobe(iteration_strobe), .busy(busy5), .stage_strobe(ss5),
    .done(dn5), .butterfly_count(bc5), .stage_count(sc5), .addr_a(aa5),
    .addr_b(ab5), .twiddle_addr(tw5)
  );

  fft_iter_sequencer #(.LOG2_POINTS(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .iteration_strobe(iteration_strobe), .busy(busy3), .stage_strobe(ss3),
    .done(dn3), .butterfly_count(bc3), .stage_count(sc3), .addr_a(aa3),
    .addr_b(ab3), .twiddle_addr(tw3)
  );

  typedef struct {
    int idx;
    bit ss;
    bit dn;
    bit busy;
    int k;
    int s;
  } exp_t;

  typedef struct {
    int idx;
    int s;
    int k;
    int a;
    int b;
    int tw;
  } addr_vec_t;

  exp_t q[$];
  int   mmode[2];
  int   mn[2];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   pss0   = 0;
  int   pdn0   = 0;
  int   pdn1   = 0;
  addr_vec_t vecs[10];

  function automatic int half(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic int total(input int i);
    return (i == 0) ? 80 : 12;
  endfunction

  function automatic int exp_tw(input int tw);
`ifdef FFT_ITER_TWIDDLE_EN
    return tw;
`else
    return 0;
`endif
  endfunction

  // One clock: drive inputs, push model expectations, clock, pop and compare.
  task automatic cyc(input bit rs, input bit st, input bit it, input bit cl);
    exp_t e;
    int a_k, a_s;
    bit a_ss, a_dn, a_busy;
    reset = rs; start = st; iteration_strobe = it; clear = cl;
    for (int i = 0; i < 2; i++) begin
      e.idx = i; e.ss = 1'b0; e.dn = 1'b0;
      if (rs || cl) begin
        mmode[i] = 0; mn[i] = 0;
      end else begin
        case (mmode[i])
          0: if (st) begin mmode[i] = 1; mn[i] = 0; end
          1: if (it) begin
               mn[i]++;
               if (mn[i] % half(i) == 0) e.ss = 1'b1;
               if (mn[i] == total(i)) begin
                 e.dn = 1'b1; mmode[i] = 2; mn[i] = 0;
               end
             end
          default: mmode[i] = 0;
        endcase
      end
      e.busy = (mmode[i] == 1);
      e.k = mn[i] % half(i);
      e.s = mn[i] / half(i);
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0; iteration_strobe = 1'b0; clear = 1'b0;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.idx == 0) begin
        a_ss = ss5; a_dn = dn5; a_busy = busy5; a_k = int'(bc5); a_s = int'(sc5);
        pss0 += int'(ss5); pdn0 += int'(dn5);
      end else begin
        a_ss = ss3; a_dn = dn3; a_busy = busy3; a_k = int'(bc3); a_s = int'(sc3);
        pdn1 += int'(dn3);
      end
      n_cmp++;
      if (a_ss !== e.ss || a_dn !== e.dn || a_busy !== e.busy || a_k != e.k || a_s != e.s) begin
        n_fail++;
        $display("FAIL cycle dut%0d @%0t: got ss=%0b done=%0b busy=%0b k=%0d s=%0d, want ss=%0b done=%0b busy=%0b k=%0d s=%0d",
                 e.idx, $time, a_ss, a_dn, a_busy, a_k, a_s, e.ss, e.dn, e.busy, e.k, e.s);
      end
    end
  endtask

  task automatic check_addr(input int idx, input int a, input int b, input int tw, input string name);
    int ga, gb, gt;
    if (idx == 0) begin ga = int'(aa5); gb = int'(ab5); gt = int'(tw5); end
    else          begin ga = int'(aa3); gb = int'(ab3); gt = int'(tw3); end
    n_cmp++;
    if (ga != a || gb != b || gt != exp_tw(tw)) begin
      n_fail++;
      $display("FAIL %s: got addr_a=%0d addr_b=%0d twiddle=%0d, want %0d %0d %0d",
               name, ga, gb, gt, a, b, exp_tw(tw));
    end
  endtask

  task automatic check_int(input int got, input int want, input string name);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Strobe until the model for instance d sits at accepted-count target.
  task automatic step_to(input int d, input int target);
    int g = 0;
    while (mn[d] != target && g < 200) begin
      cyc(0, 0, 1, 0);
      g++;
    end
    if (mn[d] != target) begin
      n_cmp++; n_fail++;
      $display("FAIL step_to dut%0d: reached %0d, want %0d", d, mn[d], target);
    end
  endtask

  initial begin
    int g;
    reset = 1'b1; start = 1'b0; clear = 1'b0; iteration_strobe = 1'b0;
    mmode[0] = 0; mmode[1] = 0; mn[0] = 0; mn[1] = 0;

    vecs[0] = '{0, 0, 7, 14, 15, 0};
    vecs[1] = '{0, 1, 3, 5, 7, 8};
    vecs[2] = '{0, 2, 5, 9, 13, 4};
    vecs[3] = '{0, 3, 12, 20, 28, 8};
    vecs[4] = '{0, 4, 3, 3, 19, 3};
    vecs[5] = '{1, 0, 3, 6, 7, 0};
    vecs[6] = '{1, 1, 1, 1, 3, 2};
    vecs[7] = '{1, 1, 2, 4, 6, 0};
    vecs[8] = '{1, 2, 1, 1, 5, 1};
    vecs[9] = '{1, 2, 3, 3, 7, 3};

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check_addr(0, 0, 1, 0, "idle_addr5");
    check_addr(1, 0, 1, 0, "idle_addr3");

    // Strobes in IDLE are ignored.
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);

    // First stage back-to-back; N=8 instance completes after 12 strobes.
    pss0 = 0; pdn0 = 0; pdn1 = 0;
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);
    check_int(pss0, 1, "stage0_pulses");
    check_int(pdn1, 1, "n8_done_pulses");

    // start in RUN ignored; rest of the transform with random gaps.
    cyc(0, 1, 0, 0);
    g = 0;
    while (mmode[0] == 1 && g < 1000) begin
      cyc(0, 0, 1'($urandom_range(0, 1)), 0);
      g++;
    end
    if (g >= 1000) begin
      n_cmp++; n_fail++;
      $display("FAIL full_run: no completion within bound");
    end
    cyc(0, 0, 0, 0);
    check_int(pss0, 5, "full_run_stage_pulses");
    check_int(pdn0, 1, "full_run_done_pulses");

    // Addressing vectors for N=32.
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step_to(0, vecs[i].s * 16 + vecs[i].k);
      check_addr(0, vecs[i].a, vecs[i].b, vecs[i].tw, $sformatf("addr5_s%0d_k%0d", vecs[i].s, vecs[i].k));
    end
    cyc(0, 0, 0, 1);

    // Clear mid stage 2, then a normal transform.
    pdn0 = 0;
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 40; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    check_int(pdn0, 0, "clear_no_done");
    check_addr(0, 0, 1, 0, "clear_addr5");
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 80; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    check_int(pdn0, 1, "after_clear_done");

    // Clear together with the final strobe suppresses both pulses.
    pss0 = 0; pdn0 = 0;
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 79; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);
    check_int(pss0, 4, "final_clear_stage_pulses");
    check_int(pdn0, 0, "final_clear_done");

    // Addressing vectors for N=8.
    cyc(0, 1, 0, 0);
    for (int i = 5; i < 10; i++) begin
      step_to(1, vecs[i].s * 4 + vecs[i].k);
      check_addr(1, vecs[i].a, vecs[i].b, vecs[i].tw, $sformatf("addr3_s%0d_k%0d", vecs[i].s, vecs[i].k));
    end
    cyc(0, 0, 0, 1);

    // Reset mid-run together with a strobe.
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0);
    cyc(1, 0, 1, 0);
    check_addr(0, 0, 1, 0, "reset_addr5");
    check_addr(1, 0, 1, 0, "reset_addr3");
    cyc(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
